// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: one-entry hold register plus a 3-stage writer scoreboard for RAW stalls.
// Latency: accept on edge N, issue in cycle N+1 at the earliest; in_ready drops while the held entry is stalled.
module pipe_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_inst,
  output logic             in_ready,
  output logic             iss_valid,
  output logic [1:0]       iss_op,
  output logic [4:0]       iss_rs1,
  output logic [4:0]       iss_rs2,
  output logic [4:0]       iss_rd,
  output logic             stall,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } inst_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_t;

  inst_t          hold;
  logic           hold_v;
  sb_t   [2:0]    sb;
  logic           raw_match;
  logic           hazard;
  logic           accept;
  logic           unused_inst_bits;

  // Bits 19:5 carry no information this controller needs.
  assign unused_inst_bits = ^in_inst[19:5];

  always_comb begin
    raw_match = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb[i].v && ((sb[i].rd == hold.rs1) || (sb[i].rd == hold.rs2))) begin
        raw_match = 1'b1;
      end
    end
  end

  // NOPs (op 1x) never wait on sources.
  assign hazard    = hold_v && !hold.op[1] && raw_match;
  assign iss_valid = !rst && hold_v && !hazard;
  assign stall     = !rst && hold_v && hazard;
  assign in_ready  = !rst && (!hold_v || iss_valid);
  assign accept    = in_valid && in_ready;

  assign iss_op  = hold.op;
  assign iss_rs1 = hold.rs1;
  assign iss_rs2 = hold.rs2;
  assign iss_rd  = hold.rd;

  assign busy = hold_v || sb[0].v || sb[1].v || sb[2].v;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v    <= 1'b0;
      hold      <= '0;
      sb        <= '0;
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) begin
        hold_v   <= 1'b1;
        hold.op  <= in_inst[31:30];
        hold.rs1 <= in_inst[29:25];
        hold.rs2 <= in_inst[24:20];
        hold.rd  <= in_inst[4:0];
      end else if (iss_valid) begin
        hold_v <= 1'b0;
      end

      // EX -> MEM -> WB; the WB entry retires on this edge.
      sb[0].v  <= iss_valid && !hold.op[1];
      sb[0].rd <= hold.rd;
      sb[1]    <= sb[0];
      sb[2]    <= sb[1];

      if (iss_valid) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl with an accepted-instruction scoreboard queue.
module tb_pipe_issue_ctrl;

  localparam int CW = 4;

  localparam logic [31:0] I_ADD3  = 32'h0220_0003; // r3 = r1 + r2
  localparam logic [31:0] I_SUB5  = 32'h4220_0005; // r5 = r1 - r2
  localparam logic [31:0] I_ADD4  = 32'h0610_0004; // r4 = r3 + r1
  localparam logic [31:0] I_NOP   = 32'h8000_0000;
  localparam logic [31:0] I_ADD1  = 32'h0000_0001; // r1 = r0 + r0

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [31:0]   in_inst = '0;
  logic          in_ready;
  logic          iss_valid;
  logic [1:0]    iss_op;
  logic [4:0]    iss_rs1;
  logic [4:0]    iss_rs2;
  logic [4:0]    iss_rd;
  logic          stall;
  logic          busy;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] stall_cnt;

  pipe_issue_ctrl #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .iss_valid (iss_valid),
    .iss_op    (iss_op),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .stall     (stall),
    .busy      (busy),
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          cyc;
  logic        last_acc;
  logic        iv_log [32];
  logic        st_log [32];
  logic        rdy_log[32];
  logic        acc_log[32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record acceptance before the edge, then sample #1 after it.
  task automatic tick();
    logic        a;
    logic        r;
    logic [31:0] snap;
    logic [31:0] e;
    a    = in_valid && in_ready;
    r    = rst;
    snap = in_inst;
    if (cyc >= 0 && cyc < 32) acc_log[cyc] = a;
    @(posedge clk);
    #1;
    if (r) exp_q.delete();
    else if (a) exp_q.push_back(snap);
    last_acc = a;
    cyc++;
    if (cyc >= 0 && cyc < 32) begin
      iv_log[cyc]  = iss_valid;
      st_log[cyc]  = stall;
      rdy_log[cyc] = in_ready;
    end
    if (iss_valid === 1'b1) begin
      chk("iss_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("iss_fields", {15'd0, iss_op, iss_rs1, iss_rs2, iss_rd},
            {15'd0, e[31:30], e[29:25], e[24:20], e[4:0]});
      end
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 32; i++) begin
      iv_log[i] = 1'b0; st_log[i] = 1'b0; rdy_log[i] = 1'b0; acc_log[i] = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    #1;
    clear_logs();
  endtask

  task automatic feed(input logic [31:0] inst);
    int budget;
    in_valid = 1'b1;
    in_inst  = inst;
    budget   = 0;
    last_acc = 1'b0;
    while (!last_acc && budget < 20) begin
      tick();
      budget++;
    end
    chk("accept_timeout", 32'(last_acc), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    cyc = -100;
    clear_logs();

    // Reset values after release
    do_reset();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_iss_valid", 32'(iss_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_iss_fields", {15'd0, iss_op, iss_rs1, iss_rs2, iss_rd}, 32'd0);

    // Independent ADD then SUB
    in_valid = 1'b1; in_inst = I_ADD3; tick();
    in_inst = I_SUB5; tick();
    in_valid = 1'b0; tick();
    chk("indep_iv1", 32'(iv_log[1]), 32'd1);
    chk("indep_iv2", 32'(iv_log[2]), 32'd1);
    chk("indep_iv3", 32'(iv_log[3]), 32'd0);
    chk("indep_stall2", 32'(st_log[2]), 32'd0);
    chk("indep_issue_cnt", 32'(issue_cnt), 32'd2);
    chk("indep_stall_cnt", 32'(stall_cnt), 32'd0);
    idle(4);
    chk("indep_busy_drained", 32'(busy), 32'd0);
    chk("indep_q_empty", 32'(exp_q.size()), 32'd0);

    // RAW hazard with a held-off follower
    do_reset();
    in_valid = 1'b1; in_inst = I_ADD3; tick();
    in_inst = I_ADD4; tick();
    in_inst = I_SUB5;
    while (cyc < 5) tick();
    chk("raw_rs1_c5", 32'(iss_rs1), 32'd3);
    chk("raw_rs2_c5", 32'(iss_rs2), 32'd1);
    chk("raw_rd_c5", 32'(iss_rd), 32'd4);
    tick();
    in_valid = 1'b0;
    tick();
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("raw_stall_c%0d", c), 32'(st_log[c]), 32'd1);
      chk($sformatf("raw_iv_c%0d", c), 32'(iv_log[c]), 32'd0);
      chk($sformatf("raw_rdy_c%0d", c), 32'(rdy_log[c]), 32'd0);
    end
    chk("raw_stall_c5", 32'(st_log[5]), 32'd0);
    chk("raw_iv_c5", 32'(iv_log[5]), 32'd1);
    chk("raw_rdy_c5", 32'(rdy_log[5]), 32'd1);
    chk("raw_acc_e4", 32'(acc_log[4]), 32'd0);
    chk("raw_acc_e5", 32'(acc_log[5]), 32'd1);
    chk("raw_iv_c6", 32'(iv_log[6]), 32'd1);
    chk("raw_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("raw_issue_cnt", 32'(issue_cnt), 32'd3);
    idle(4);
    chk("raw_q_empty", 32'(exp_q.size()), 32'd0);

    // NOP with rd=0 must not block a reader of r0
    do_reset();
    in_valid = 1'b1; in_inst = I_NOP; tick();
    in_inst = I_ADD1; tick();
    in_valid = 1'b0; tick();
    chk("nop_iv1", 32'(iv_log[1]), 32'd1);
    chk("nop_iv2", 32'(iv_log[2]), 32'd1);
    chk("nop_stall2", 32'(st_log[2]), 32'd0);
    chk("nop_stall_cnt", 32'(stall_cnt), 32'd0);
    idle(4);

    // Reset in the middle of a stall
    do_reset();
    in_valid = 1'b1; in_inst = I_ADD3; tick();
    in_inst = I_ADD4; tick();
    in_valid = 1'b0; tick();
    chk("mid_stall_c3", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_post_iss_valid", 32'(iss_valid), 32'd0);
    chk("mid_post_busy", 32'(busy), 32'd0);
    chk("mid_post_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("mid_post_issue_cnt", 32'(issue_cnt), 32'd0);
    idle(6);
    for (int c = 5; c <= 10; c++) chk($sformatf("mid_no_iss_c%0d", c), 32'(iv_log[c]), 32'd0);

    // Counter wrap (issue) and saturation (stall) with a narrow counter
    do_reset();
    for (int k = 0; k < 17; k++) feed(I_ADD3);
    idle(1);
    chk("wrap_issue_cnt", 32'(issue_cnt), 32'd1);
    chk("wrap_stall_cnt", 32'(stall_cnt), 32'd0);
    for (int k = 0; k < 6; k++) begin
      feed(I_ADD3);
      feed(I_ADD4);
    end
    idle(8);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    chk("sat_issue_cnt", 32'(issue_cnt), 32'd13);
    chk("sat_q_empty", 32'(exp_q.size()), 32'd0);
    chk("sat_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_issue_ctrl.md
PIPE_ISSUE_CTRL -- requirements
Module: pipe_issue_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the issue and stall counters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream fetch presents an instruction.
REQ-005 in_inst  input  32  instruction: op[31:30], rs1[29:25], rs2[24:20], rd[4:0].
REQ-006 in_ready  output  1  controller accepts in_inst this cycle.
REQ-007 iss_valid  output  1  instruction issued to the execute stage this cycle.
REQ-008 iss_op  output  2  issued op: 00 ADD, 01 SUB, 1x NOP.
REQ-009 iss_rs1 / iss_rs2 / iss_rd  output  5 each  issued register indices.
REQ-010 stall  output  1  held instruction is blocked by a hazard this cycle.
REQ-011 busy  output  1  held instruction or any in-flight writer present.
REQ-012 issue_cnt  output  CNT_W  count of issued instructions.
REQ-013 stall_cnt  output  CNT_W  count of stall cycles.

Function
REQ-014 One-entry hold register (hold_v, hold_inst) captures in_inst on the rising edge when in_valid && in_ready.
REQ-015 in_ready = !rst && (!hold_v || iss_valid); simultaneous issue and accept replaces the hold entry on the same edge.
REQ-016 Writer: op 00 or 01; op 1x is a NOP, is never a writer, and its sources are never checked.
REQ-017 Scoreboard: three entries sb[0..2] (valid + rd) tracking the EX, MEM and WB stages of issued writers.
REQ-018 Each edge: sb[0] <= {iss_valid && writer(iss_op), iss_rd}; sb[1] <= sb[0]; sb[2] <= sb[1]; the prior sb[2] retires.
REQ-019 hazard = hold_v && hold op is ADD/SUB && some valid sb[i] has rd equal to hold rs1 or hold rs2; r0 is not special.
REQ-020 iss_valid = hold_v && !hazard (combinational); iss_* fields are decoded from hold_inst.
REQ-021 stall = hold_v && hazard.
REQ-022 Latency: an instruction accepted on edge N issues in cycle N+1 at the earliest.
REQ-023 Independent instructions issue one per cycle.
REQ-024 A dependent instruction issues no earlier than 4 cycles after its producer, i.e. 3 stall cycles.
REQ-025 State (derived): EMPTY (!hold_v); READY (hold_v && !hazard); STALL (hold_v && hazard).
REQ-026 State transitions:
- EMPTY -> READY/STALL on accept.
- STALL -> READY when the matching entry retires.
- READY -> EMPTY on issue without accept.
- READY -> READY/STALL on issue with accept.
REQ-027 issue_cnt increments by 1 per iss_valid cycle and wraps modulo 2^CNT_W.
REQ-028 stall_cnt increments by 1 per stall cycle and saturates at all-ones.
REQ-029 busy = hold_v || sb[0].v || sb[1].v || sb[2].v.
REQ-030 in_inst is ignored when in_valid is low; the hold entry is never overwritten while stalled.

Reset
REQ-031 While rst is high at an edge: hold_v, all sb valid bits, issue_cnt and stall_cnt clear to 0.
REQ-032 During rst: in_ready=0, iss_valid=0, stall=0.
REQ-033 After the reset edge: busy=0, all iss_* fields=0.
REQ-034 Reset mid-operation discards the held instruction and all scoreboard entries; nothing issues from pre-reset state.

Verification
REQ-035 Reset: assert rst 2 cycles, then release -> in_ready=1, iss_valid=0, busy=0, issue_cnt=0, stall_cnt=0.
REQ-036 Independent instructions:
- Stimulus: 0x02200003 (ADD r3=r1+r2) accepted edge 0, then 0x42200005 (SUB r5=r1-r2) accepted edge 1.
- Response: iss_valid in cycles 1 and 2; issue_cnt=2; stall_cnt=0.
REQ-037 RAW hazard:
- Stimulus: 0x02200003 accepted edge 0, then 0x06100004 (ADD r4=r3+r1) accepted edge 1.
- Response: stall=1 in cycles 2-4; second issue in cycle 5 with iss_rs1=3, iss_rs2=1, iss_rd=4; stall_cnt=3.
REQ-038 NOP is not a writer:
- Stimulus: 0x80000000 (NOP, rd=0) then 0x00000001 (ADD r1=r0+r0).
- Response: no stall; issues on consecutive cycles.
REQ-039 Backpressure:
- Stimulus: during the REQ-037 stall, hold in_valid=1 with 0x42200005.
- Response: in_ready=0 in cycles 2-4; 0x42200005 accepted on edge 5 and issued in cycle 6.
REQ-040 Reset mid-stall:
- Stimulus: assert rst in cycle 3 of REQ-037.
- Response: from the next cycle, iss_valid=0, busy=0, stall_cnt=0; 0x06100004 never issues.
